// File: rtl/cam_frame_capture.sv
// Camera byte-stream capture: turns pclk/vsync/href/din into addressed framebuffer
// writes in RAW, RGB565, Y or 2x2-decimated Y format, with per-frame geometry status.
module cam_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int CNT_W    = 8
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              cap_en,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy
);

    localparam int LINE_BYTES = 2 * H_ACTIVE;
    localparam int LIM_RAW    = 2 * H_ACTIVE * V_ACTIVE;
    localparam int LIM_PIX    = H_ACTIVE * V_ACTIVE;
    localparam int LIM_DEC    = (H_ACTIVE / 2) * (V_ACTIVE / 2);
    localparam int WC_W       = $clog2(LIM_RAW + 1);
    localparam int BC_W       = $clog2(LINE_BYTES + 2);
    localparam int LC_W       = $clog2(V_ACTIVE + 3);

    localparam logic [1:0] M_RAW = 2'd0;
    localparam logic [1:0] M_RGB = 2'd1;
    localparam logic [1:0] M_Y   = 2'd2;
    localparam logic [1:0] M_DEC = 2'd3;

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, SKIP} state_t;

    state_t            state_q, state_d;
    logic              cfg_en_q, cfg_en_d;
    logic [1:0]        cfg_mode_q, cfg_mode_d;
    logic              phase_q, phase_d;
    logic              pix_odd_q, pix_odd_d;
    logic              line_odd_q, line_odd_d;
    logic              in_line_q, in_line_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;

    logic [WC_W-1:0]   limit;
    logic [BC_W-1:0]   bytes_now;
    logic [LC_W-1:0]   lines_final;
    logic              line_end;
    logic              want_wr;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_en_q   <= 1'b0;
            cfg_mode_q <= M_RAW;
            phase_q    <= 1'b0;
            pix_odd_q  <= 1'b0;
            line_odd_q <= 1'b0;
            in_line_q  <= 1'b0;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
            hi_q       <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cfg_en_q   <= cfg_en_d;
            cfg_mode_q <= cfg_mode_d;
            phase_q    <= phase_d;
            pix_odd_q  <= pix_odd_d;
            line_odd_q <= line_odd_d;
            in_line_q  <= in_line_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
            hi_q       <= hi_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_comb begin
        case (cfg_mode_q)
            M_RAW:   limit = WC_W'(LIM_RAW);
            M_DEC:   limit = WC_W'(LIM_DEC);
            default: limit = WC_W'(LIM_PIX);
        endcase
    end

    // Byte and line counts saturate one past nominal so long lines/frames still flag.
    always_comb begin
        if (href && byte_cnt_q != BC_W'(LINE_BYTES + 1)) begin
            bytes_now = byte_cnt_q + BC_W'(1);
        end else begin
            bytes_now = byte_cnt_q;
        end
        line_end    = href | in_line_q;
        lines_final = line_cnt_q + LC_W'(line_end);
        case (cfg_mode_q)
            M_RAW:   want_wr = 1'b1;
            M_RGB:   want_wr = phase_q;
            M_Y:     want_wr = ~phase_q;
            default: want_wr = ~phase_q & ~pix_odd_q & ~line_odd_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cfg_en_d   = cfg_en_q;
        cfg_mode_d = cfg_mode_q;
        phase_d    = href ? ~phase_q : 1'b0;
        pix_odd_d  = pix_odd_q;
        line_odd_d = line_odd_q;
        in_line_d  = in_line_q;
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        hi_d       = hi_q;
        wr_cnt_d   = wr_cnt_q;
        addr_d     = we_q ? addr_q + ADDR_W'(1) : addr_q;
        dout_d     = dout_q;
        we_d       = 1'b0;
        err_d      = err_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;
        fcnt_d     = fcnt_q;

        if (vsync) begin
            cfg_en_d   = cap_en;
            cfg_mode_d = mode;
        end

        case (state_q)
            IDLE: begin
                if (vsync) state_d = SYNC;
            end
            SYNC: begin
                addr_d     = '0;
                phase_d    = 1'b0;
                pix_odd_d  = 1'b0;
                line_odd_d = 1'b0;
                in_line_d  = 1'b0;
                byte_cnt_d = '0;
                line_cnt_d = '0;
                wr_cnt_d   = '0;
                if (!vsync) begin
                    state_d = cfg_en_q ? ACTIVE : SKIP;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (vsync) begin
                    // A line still open at vsync is closed here; its last byte is not written.
                    state_d = SYNC;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + CNT_W'(1);
                    ferr_d  = err_q | ovf_q
                            | (line_end && bytes_now != BC_W'(LINE_BYTES))
                            | (lines_final != LC_W'(V_ACTIVE));
                end else if (href) begin
                    byte_cnt_d = bytes_now;
                    in_line_d  = 1'b1;
                    if (phase_q) pix_odd_d = ~pix_odd_q;
                    else         hi_d      = din;
                    if (want_wr) begin
                        if (wr_cnt_q < limit) begin
                            we_d     = 1'b1;
                            dout_d   = (cfg_mode_q == M_RGB) ? {hi_q, din} : {8'h00, din};
                            wr_cnt_d = wr_cnt_q + WC_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    pix_odd_d = 1'b0;
                    if (in_line_q) begin
                        in_line_d  = 1'b0;
                        byte_cnt_d = '0;
                        line_odd_d = ~line_odd_q;
                        if (line_cnt_q != LC_W'(V_ACTIVE + 1)) line_cnt_d = line_cnt_q + LC_W'(1);
                        if (byte_cnt_q != BC_W'(LINE_BYTES)) err_d = 1'b1;
                    end
                end
            end
            SKIP: begin
                if (vsync) state_d = SYNC;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;
    assign frame_cnt  = fcnt_q;
    assign busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomised bench for cam_frame_capture; expected writes and frame status come from
// a per-frame model that lists the bytes each format keeps and truncates at the limit.
module tb_cam_frame_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 5;
    localparam int CW = 3;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          cap_en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] addr;
    logic [15:0]   dout;
    logic          we;
    logic          frame_done;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;
    logic          busy;

    cam_frame_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W(AW),
        .CNT_W(CW)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .vsync(vsync),
        .href(href),
        .din(din),
        .cap_en(cap_en),
        .mode(mode),
        .addr(addr),
        .dout(dout),
        .we(we),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] obs_addr[$];
    logic [15:0]   obs_data[$];
    int            done_seen = 0;
    logic [15:0]   exp_data[$];
    logic          exp_err = 1'b0;
    logic          model_err = 1'b0;
    bit            pending = 1'b0;
    int            model_cnt = 0;
    logic [7:0]    fb[4][16];
    int            lens[4];

    always @(negedge pclk) begin
        if (rst_n) begin
            if (we) begin
                obs_addr.push_back(addr);
                obs_data.push_back(dout);
            end
            if (frame_done) done_seen++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Kept bytes per format, in stream order, capped at the per-frame write limit.
    task automatic build_expect(input int m, input int nl, input bit overlap);
        int limit;
        int cand;
        bit err;
        exp_data.delete();
        cand = 0;
        err = (nl != V);
        limit = (m == 0) ? 2 * H * V : (m == 3) ? (H / 2) * (V / 2) : H * V;
        for (int l = 0; l < nl; l++) begin
            if (lens[l] != 2 * H) err = 1'b1;
            for (int b = 0; b < lens[l]; b++) begin
                bit keep;
                logic [15:0] w;
                if (overlap && l == nl - 1 && b == lens[l] - 1) continue;
                keep = 1'b0;
                w = {8'h00, fb[l][b]};
                case (m)
                    0: keep = 1'b1;
                    1: begin
                        keep = (b % 2 == 1);
                        if (keep) w = {fb[l][b-1], fb[l][b]};
                    end
                    2: keep = (b % 2 == 0);
                    default: keep = (b % 4 == 0) && (l % 2 == 0);
                endcase
                if (keep) begin
                    cand++;
                    if (cand <= limit) exp_data.push_back(w);
                end
            end
        end
        exp_err = err | (cand > limit);
    endtask

    task automatic close_frame();
        if (pending) begin
            checkOutput("wr_count", obs_addr.size(), exp_data.size());
            for (int i = 0; i < obs_addr.size() && i < exp_data.size(); i++) begin
                checkOutput("wr_addr", obs_addr[i], i);
                checkOutput("wr_data", obs_data[i], exp_data[i]);
            end
            checkOutput("done_pulses", done_seen, 1);
            model_cnt = (model_cnt + 1) % (1 << CW);
            model_err = exp_err;
        end else begin
            checkOutput("wr_count_nocap", obs_addr.size(), 0);
            checkOutput("done_pulses_nocap", done_seen, 0);
        end
        checkOutput("frame_err", frame_err, model_err);
        checkOutput("frame_cnt", frame_cnt, model_cnt);
        obs_addr.delete();
        obs_data.delete();
        pending = 1'b0;
    endtask

    task automatic send_vsync(input bit en, input int m);
        done_seen = 0;
        vsync  = 1'b1;
        href   = 1'b0;
        cap_en = en;
        mode   = 2'(m);
        repeat (4) tick();
        vsync  = 1'b0;
        cap_en = 1'($urandom);
        mode   = 2'($urandom);
        tick();
        tick();
        close_frame();
        checkOutput("busy", busy, en);
    endtask

    task automatic applyStimulus(input int m, input bit en, input int nl, input bit overlap, input bit toggle);
        send_vsync(en, m);
        build_expect(m, nl, overlap);
        pending = en;
        for (int l = 0; l < nl; l++) begin
            bit last;
            last = overlap && (l == nl - 1);
            for (int b = 0; b < lens[l]; b++) begin
                href = 1'b1;
                din  = fb[l][b];
                if (toggle && l == 0 && b == 1) cap_en = ~en;
                if (last && b == lens[l] - 1) vsync = 1'b1;
                tick();
            end
            if (!last) begin
                href = 1'b0;
                din  = 8'($urandom);
                repeat (3) tick();
            end
        end
    endtask

    task automatic fill_seq();
        for (int l = 0; l < 4; l++) begin
            lens[l] = 2 * H;
            for (int b = 0; b < 16; b++) fb[l][b] = 8'(8'h10 + 8 * l + b);
        end
    endtask

    task automatic fill_rand();
        for (int l = 0; l < 4; l++) begin
            lens[l] = ($urandom_range(0, 9) < 7) ? 2 * H : int'($urandom_range(2 * H - 3, 2 * H + 2));
            for (int b = 0; b < 16; b++) fb[l][b] = 8'($urandom);
        end
    endtask

    task automatic reset_mid_line();
        fill_seq();
        send_vsync(1'b1, 0);
        for (int b = 0; b < 3; b++) begin
            href = 1'b1;
            din  = fb[0][b];
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_cnt", frame_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        obs_addr.delete();
        obs_data.delete();
        pending   = 1'b0;
        model_cnt = 0;
        model_err = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        for (int b = 0; b < 6; b++) begin
            href = 1'b1;
            din  = 8'($urandom);
            tick();
        end
        href = 1'b0;
        tick();
        checkOutput("wr_after_reset", obs_addr.size(), 0);
        checkOutput("busy_after_reset", busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("init_addr", addr, 0);
        checkOutput("init_we", we, 0);
        checkOutput("init_cnt", frame_cnt, 0);
        checkOutput("init_err", frame_err, 0);
        checkOutput("init_busy", busy, 0);

        fill_seq();
        applyStimulus(1, 1'b1, 2, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 2, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 2, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 2, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 2, 1'b0, 1'b0);
        lens[1] = 6;
        applyStimulus(2, 1'b1, 2, 1'b0, 1'b0);
        fill_seq();
        applyStimulus(2, 1'b1, 2, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 3, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 2, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 2, 1'b1, 1'b0);

        reset_mid_line();
        fill_seq();
        applyStimulus(1, 1'b1, 2, 1'b0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            fill_rand();
            applyStimulus(int'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0),
                          int'($urandom_range(1, 3)), ($urandom_range(0, 6) == 0),
                          1'($urandom));
        end
        send_vsync(1'b0, 0);
        send_vsync(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
